// File: rtl/cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor
//
// Sits between the cache arbiter's line-wide memory port and physical memory.
// A single LINE_W-bit line read or write from the arbiter becomes a burst of
// BEATS transfers of BURST_W bits on the pmem bus, beat 0 carrying line bits
// [BURST_W-1:0] and later beats ascending. Towards the arbiter the block looks
// like a line-granular memory: the request is held until a one-cycle resp.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous, active-high reset; aborts a burst in flight
//   line_addr_i    line address from the arbiter
//   line_wdata_i   line to be written
//   line_read_i    line read request
//   line_write_i   line write request (wins if both requests are high)
//   line_rdata_o   assembled read line, valid in the resp cycle of a read
//   line_resp_o    one-cycle completion pulse
//   burst_addr_o   line-aligned burst address, zero outside a burst
//   burst_wdata_o  write beat currently offered to pmem
//   burst_rdata_i  read beat returned by pmem
//   burst_read_o   burst read request, held for the whole burst
//   burst_write_o  burst write request, held for the whole burst
//   burst_resp_i   pmem beat strobe, one beat transferred per high cycle
// -----------------------------------------------------------------------------
module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  line_addr_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  input  logic               line_read_i,
  input  logic               line_write_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic [ADDR_W-1:0]  burst_addr_o,
  output logic [BURST_W-1:0] burst_wdata_o,
  input  logic [BURST_W-1:0] burst_rdata_i,
  output logic               burst_read_o,
  output logic               burst_write_o,
  input  logic               burst_resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);

  // Byte-offset bits inside a line; cleared so pmem always sees a line base.
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   rdata_q;

  logic [CNT_W-1:0]    cnt_inc;
  logic                last_beat;
  logic [ADDR_W-1:0]   aligned_addr;

  assign cnt_inc      = cnt + CNT_W'(1);
  assign last_beat    = (cnt == LAST_BEAT);
  assign aligned_addr = line_addr_i & ~OFF_MASK;

  // The read line stays visible after DONE until a later read overwrites it
  // beat by beat; a written line is never reflected here.
  assign line_rdata_o = rdata_q;

  // All bus-facing outputs are registered and change together with the state,
  // so burst_read_o/burst_write_o are high exactly while in READ/WRITE and
  // line_resp_o is high exactly while in DONE.
  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // a blocking = would let later statements read the freshly updated cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      line_resp_o   <= 1'b0;
      burst_addr_o  <= '0;
      burst_wdata_o <= '0;
      burst_read_o  <= 1'b0;
      burst_write_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Line inputs are only sampled here; the write request has priority.
          cnt <= '0;
          if (line_write_i) begin
            state         <= WRITE;
            burst_addr_o  <= aligned_addr;
            wdata_q       <= line_wdata_i;
            burst_wdata_o <= line_wdata_i[BURST_W-1:0];
            burst_write_o <= 1'b1;
          end else if (line_read_i) begin
            state         <= READ;
            burst_addr_o  <= aligned_addr;
            burst_read_o  <= 1'b1;
          end
        end

        READ: begin
          // Beats may arrive with gaps; a cycle without burst_resp_i just waits.
          if (burst_resp_i) begin
            rdata_q[int'(cnt)*BURST_W +: BURST_W] <= burst_rdata_i;
            if (last_beat) begin
              cnt          <= '0;
              state        <= DONE;
              burst_read_o <= 1'b0;
              burst_addr_o <= '0;
              line_resp_o  <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        WRITE: begin
          // The next beat is presented one cycle after pmem accepts the current.
          if (burst_resp_i) begin
            if (last_beat) begin
              cnt           <= '0;
              state         <= DONE;
              burst_write_o <= 1'b0;
              burst_addr_o  <= '0;
              burst_wdata_o <= '0;
              line_resp_o   <= 1'b1;
            end else begin
              cnt           <= cnt_inc;
              burst_wdata_o <= wdata_q[int'(cnt_inc)*BURST_W +: BURST_W];
            end
          end
        end

        DONE: begin
          // Single-cycle completion; a request still high next cycle restarts.
          state       <= IDLE;
          line_resp_o <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_addr_i;
  logic [255:0] line_wdata_i;
  logic         line_read_i;
  logic         line_write_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  burst_addr_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i;
  logic         burst_read_o;
  logic         burst_write_o;
  logic         burst_resp_i;

  cacheline_burst_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .line_addr_i   (line_addr_i),
    .line_wdata_i  (line_wdata_i),
    .line_read_i   (line_read_i),
    .line_write_i  (line_write_i),
    .line_rdata_o  (line_rdata_o),
    .line_resp_o   (line_resp_o),
    .burst_addr_o  (burst_addr_o),
    .burst_wdata_o (burst_wdata_o),
    .burst_rdata_i (burst_rdata_i),
    .burst_read_o  (burst_read_o),
    .burst_write_o (burst_write_o),
    .burst_resp_i  (burst_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    bit           is_read;
    logic [255:0] line;
  } resp_t;

  beat_t exp_beats[$];
  resp_t exp_resps[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit forbid_read = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every transferred beat and every line resp against the
  // scoreboard queues filled by the stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      if (burst_resp_i && (burst_read_o || burst_write_o)) begin
        if (exp_beats.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL beat_unexpected: got addr %h with no beat pending", burst_addr_o);
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          check("beat_dir", 256'(burst_write_o), 256'(e.is_write));
          check("beat_addr", 256'(burst_addr_o), 256'(e.addr));
          if (e.is_write) check("beat_wdata", 256'(burst_wdata_o), 256'(e.data));
        end
      end
      if (line_resp_o) begin
        if (exp_resps.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL resp_unexpected: got line_resp_o=1 with no request pending");
        end else begin
          resp_t r;
          r = exp_resps.pop_front();
          if (r.is_read) check("read_line", line_rdata_o, r.line);
        end
      end
      if (forbid_read) check("no_read_on_conflict", 256'(burst_read_o), 256'(0));
    end
  end

  task automatic wait_burst(input bit is_write, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(is_write ? burst_write_o : burst_read_o) && lat < 20);
    if (!(is_write ? burst_write_o : burst_read_o))
      check("burst_start_timeout", 256'(0), 256'(1));
  endtask

  task automatic run_beats(input logic [3:0][63:0] beats, input int gap,
                           input bit is_write, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin
        tick();
        check("req_held", 256'(is_write ? burst_write_o : burst_read_o), 256'(1));
      end
      burst_resp_i  = 1'b1;
      burst_rdata_i = is_write ? 64'h0 : beats[i];
      tick();
      burst_resp_i  = 1'b0;
      burst_rdata_i = 64'h0;
    end
  endtask

  task automatic push_beats(input bit is_write, input logic [31:0] addr,
                            input logic [3:0][63:0] beats, input int n);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.is_write = is_write;
      e.addr     = addr;
      e.data     = beats[i];
      exp_beats.push_back(e);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [3:0][63:0] beats, input logic [255:0] exp_line,
                         input int gap, output int lat);
    resp_t r;
    line_addr_i = addr;
    line_read_i = 1'b1;
    push_beats(1'b0, exp_addr, beats, 4);
    r.is_read = 1'b1;
    r.line    = exp_line;
    exp_resps.push_back(r);
    wait_burst(1'b0, lat);
    run_beats(beats, gap, 1'b0, 4);
    check("resp_after_read", 256'(line_resp_o), 256'(1));
    line_read_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] line, input logic [3:0][63:0] exp_beats_in,
                          input int gap, input bit also_read, output int lat);
    resp_t r;
    line_addr_i  = addr;
    line_wdata_i = line;
    line_write_i = 1'b1;
    line_read_i  = also_read;
    push_beats(1'b1, exp_addr, exp_beats_in, 4);
    r.is_read = 1'b0;
    r.line    = '0;
    exp_resps.push_back(r);
    wait_burst(1'b1, lat);
    run_beats(exp_beats_in, gap, 1'b1, 4);
    check("resp_after_write", 256'(line_resp_o), 256'(1));
    line_write_i = 1'b0;
    line_read_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][63:0] b1, bw, bc, br, bf, bb;
    logic [255:0]     l1, lw, lc, lf, lb;
    int lat;

    b1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    bw = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    lw = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
    bc = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
          64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    lc = 256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101;
    br = {64'h0, 64'h0, 64'hBAD0_0000_0000_0002, 64'hBAD0_0000_0000_0001};
    bf = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
          64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    lf = 256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555;
    bb = {64'h0F0F_0F0F_0F0F_0F0F, 64'h0E0E_0E0E_0E0E_0E0E,
          64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C};
    lb = 256'h0F0F0F0F0F0F0F0F_0E0E0E0E0E0E0E0E_0D0D0D0D0D0D0D0D_0C0C0C0C0C0C0C0C;

    rst           = 1'b1;
    line_addr_i   = '0;
    line_wdata_i  = '0;
    line_read_i   = 1'b0;
    line_write_i  = 1'b0;
    burst_rdata_i = '0;
    burst_resp_i  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_resp", 256'(line_resp_o), 256'(0));
    check("rst_read", 256'(burst_read_o), 256'(0));
    check("rst_write", 256'(burst_write_o), 256'(0));
    check("rst_addr", 256'(burst_addr_o), 256'(0));
    check("rst_wdata", 256'(burst_wdata_o), 256'(0));
    check("rst_rdata", line_rdata_o, 256'(0));
    rst = 1'b0;
    tick();

    // Consecutive-beat read
    do_read(32'h0000_1234, 32'h0000_1220, b1, l1, 0, lat);
    check("read_start_latency", 256'(lat), 256'(1));
    tick();
    check("resp_one_cycle", 256'(line_resp_o), 256'(0));
    check("addr_zero_idle", 256'(burst_addr_o), 256'(0));

    // Read with 2-cycle gaps between beats
    do_read(32'h0000_1234, 32'h0000_1220, b1, l1, 2, lat);
    tick();

    // Write burst
    do_write(32'h0000_4000, 32'h0000_4000, lw, bw, 0, 1'b0, lat);
    check("write_start_latency", 256'(lat), 256'(1));
    tick();
    check("line_not_echoed", line_rdata_o, l1);

    // Read and write together: write only
    forbid_read = 1'b1;
    do_write(32'h0000_2A3F, 32'h0000_2A20, lc, bc, 1, 1'b1, lat);
    tick();
    forbid_read = 1'b0;

    // Reset after 2nd read beat
    line_addr_i = 32'h0000_5678;
    line_read_i = 1'b1;
    push_beats(1'b0, 32'h0000_5660, br, 2);
    wait_burst(1'b0, lat);
    run_beats(br, 0, 1'b0, 2);
    rst         = 1'b1;
    line_read_i = 1'b0;
    tick();
    check("abort_resp", 256'(line_resp_o), 256'(0));
    check("abort_read", 256'(burst_read_o), 256'(0));
    check("abort_addr", 256'(burst_addr_o), 256'(0));
    check("abort_rdata", line_rdata_o, 256'(0));
    rst = 1'b0;
    tick();
    check("no_resp_after_abort", 256'(line_resp_o), 256'(0));
    do_read(32'h0000_5678, 32'h0000_5660, bf, lf, 0, lat);
    tick();

    // Beat strobes while idle are ignored
    for (int i = 0; i < 3; i++) begin
      burst_resp_i  = 1'b1;
      burst_rdata_i = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      tick();
      check("idle_no_resp", 256'(line_resp_o), 256'(0));
      check("idle_no_capture", line_rdata_o, lf);
    end
    burst_resp_i  = 1'b0;
    burst_rdata_i = '0;
    tick();

    // Back-to-back read then write
    do_read(32'h0000_0100, 32'h0000_0100, bb, lb, 0, lat);
    do_write(32'h0000_0200, 32'h0000_0200, lw, bw, 0, 1'b0, lat);
    check("b2b_start_latency", 256'(lat), 256'(2));
    repeat (3) tick();

    check("beats_left", 256'(exp_beats.size()), 256'(0));
    check("resps_left", 256'(exp_resps.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
